// File: rtl/counter_en.sv
// counter_en: modulo-(MAX_VAL+1) up-counter with enable, sync clear, tc and wrap pulse.
// Define COUNTER_EN_LOAD_EN to add a saturating parallel load (priority clr > load > en).
module counter_en #(
   parameter int unsigned      WIDTH   = 4,
   parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}}
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
`ifdef COUNTER_EN_LOAD_EN
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
`endif
   output logic [WIDTH-1:0] count,
   output logic             tc,
   output logic             wrap
);
   logic [WIDTH-1:0] count_q, count_d, ld_val;
   logic             wrap_q, wrap_d, ld, at_max;
`ifdef COUNTER_EN_LOAD_EN
   assign ld     = load;
   assign ld_val = load_val > MAX_VAL ? MAX_VAL : load_val;
`else
   assign ld     = 1'b0;
   assign ld_val = '0;
`endif
   assign at_max = count_q == MAX_VAL;
   always_comb begin
      count_d = clr ? '0 : ld ? ld_val : en ? (at_max ? '0 : count_q + 1'b1) : count_q;
      wrap_d  = ~clr & ~ld & en & at_max;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
         wrap_q  <= 1'b0;
      end else begin
         count_q <= count_d;
         wrap_q  <= wrap_d;
      end
   end
   assign count = count_q;
   assign wrap  = wrap_q;
   assign tc    = en & at_max & ~clr & ~ld;
endmodule

// File: tb/tb_counter_en.sv
// tb_counter_en: checks a default 4-bit counter and a MAX_VAL=9 counter against an arithmetic model.
module tb_counter_en;
   logic       clk = 0, rst_n = 1, en = 0, clr = 0, en9 = 0, clr9 = 0;
   logic [3:0] count, count9;
   logic       tc, wrap, tc9, wrap9;
   logic       ld, ld9;
   logic [3:0] lv, lv9;
   int         checks = 0, errors = 0;
   int         m_cnt = 0, m9_cnt = 0;
   bit         m_wrap = 0, m9_wrap = 0;
`ifdef COUNTER_EN_LOAD_EN
   logic       load = 0, load9 = 0;
   logic [3:0] load_val = 0, load_val9 = 0;
   assign ld = load;
   assign ld9 = load9;
   assign lv = load_val;
   assign lv9 = load_val9;
`else
   assign ld = 1'b0;
   assign ld9 = 1'b0;
   assign lv = 4'd0;
   assign lv9 = 4'd0;
`endif

   always #5 clk = ~clk;

   counter_en dut (
      .clk(clk), .rst_n(rst_n), .en(en), .clr(clr),
`ifdef COUNTER_EN_LOAD_EN
      .load(load), .load_val(load_val),
`endif
      .count(count), .tc(tc), .wrap(wrap)
   );

   counter_en #(.WIDTH(4), .MAX_VAL(4'd9)) dut9 (
      .clk(clk), .rst_n(rst_n), .en(en9), .clr(clr9),
`ifdef COUNTER_EN_LOAD_EN
      .load(load9), .load_val(load_val9),
`endif
      .count(count9), .tc(tc9), .wrap(wrap9)
   );

   function automatic int nxt(int c, logic e, logic cl, logic l, logic [3:0] v, int mx);
      if (cl) return 0;
      if (l) return int'(v) > mx ? mx : int'(v);
      if (e) return (c + 1) % (mx + 1);
      return c;
   endfunction

   function automatic bit tc_exp(int c, logic e, logic cl, logic l, int mx);
      return e && !cl && !l && c == mx;
   endfunction

   // Advance one rising edge, updating the model from the inputs present at that edge.
   task automatic tick();
      int n, n9;
      bit w, w9;
      n  = nxt(m_cnt, en, clr, ld, lv, 15);
      n9 = nxt(m9_cnt, en9, clr9, ld9, lv9, 9);
      w  = !clr && !ld && en && m_cnt == 15;
      w9 = !clr9 && !ld9 && en9 && m9_cnt == 9;
      if (!rst_n) begin
         n = 0; n9 = 0; w = 0; w9 = 0;
      end
      @(posedge clk);
      #1;
      m_cnt = n; m9_cnt = n9; m_wrap = w; m9_wrap = w9;
   endtask

   task automatic test_reset();
      en = 0; clr = 0;
      #2 rst_n = 0;
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++;
         if ({count, wrap, tc} !== 6'b0) begin
            errors++;
            $display("FAIL reset_hold: count=%0d wrap=%b tc=%b expected 0/0/0", count, wrap, tc);
         end
         tick();
      end
      rst_n = 1;
      for (int i = 0; i < 2; i++) begin
         tick();
         checks++;
         if ({count, wrap, tc} !== 6'b0) begin
            errors++;
            $display("FAIL reset_release: count=%0d wrap=%b tc=%b expected 0/0/0", count, wrap, tc);
         end
      end
   endtask

   task automatic test_count_wrap();
      int wraps = 0;
      en = 1;
      for (int i = 1; i <= 20; i++) begin
         tick();
         wraps += int'(wrap);
         checks++;
         if (count !== 4'(i % 16) || wrap !== (i == 16) || tc !== (i % 16 == 15)) begin
            errors++;
            $display("FAIL count_wrap edge %0d: count=%0d wrap=%b tc=%b expected %0d/%b/%b",
                     i, count, wrap, tc, i % 16, i == 16, i % 16 == 15);
         end
      end
      checks++;
      if (wraps != 1) begin
         errors++;
         $display("FAIL wrap_once: got %0d pulses expected 1", wraps);
      end
   endtask

   task automatic test_hold();
      en = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         checks++;
         if ({count, wrap, tc} !== {4'd4, 2'b00}) begin
            errors++;
            $display("FAIL hold: count=%0d wrap=%b tc=%b expected 4/0/0", count, wrap, tc);
         end
      end
      en = 1;
      for (int i = 1; i <= 5; i++) begin
         tick();
         checks++;
         if (count !== 4'(4 + i) || wrap !== 1'b0) begin
            errors++;
            $display("FAIL resume: count=%0d wrap=%b expected %0d/0", count, wrap, 4 + i);
         end
      end
   endtask

   task automatic test_clear_priority();
      en = 1; clr = 0;
      for (int i = 0; i < 20 && m_cnt != 15; i++) tick();
      checks++;
      if (count !== 4'd15 || tc !== 1'b1) begin
         errors++;
         $display("FAIL reach_max: count=%0d tc=%b expected 15/1", count, tc);
      end
      clr = 1;
      #1;
      checks++;
      if (tc !== 1'b0) begin
         errors++;
         $display("FAIL clr_tc: tc=%b expected 0", tc);
      end
      tick();
      checks++;
      if ({count, wrap, tc} !== 6'b0) begin
         errors++;
         $display("FAIL clr_priority: count=%0d wrap=%b tc=%b expected 0/0/0", count, wrap, tc);
      end
      clr = 0;
   endtask

   task automatic test_async_reset();
      en = 1;
      for (int i = 0; i < 20 && m_cnt != 7; i++) tick();
      checks++;
      if (count !== 4'd7) begin
         errors++;
         $display("FAIL reach_7: count=%0d expected 7", count);
      end
      #2 rst_n = 0;
      #1;
      checks++;
      if (count !== 4'd0 || wrap !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: count=%0d wrap=%b expected 0/0", count, wrap);
      end
      m_cnt = 0; m_wrap = 0; m9_cnt = 0; m9_wrap = 0;
      #1 rst_n = 1;
      tick();
      checks++;
      if (count !== 4'd1) begin
         errors++;
         $display("FAIL restart: count=%0d expected 1", count);
      end
   endtask

   task automatic test_max9();
      en = 0; en9 = 1; clr9 = 0;
      for (int i = 1; i <= 11; i++) begin
         tick();
         checks++;
         if (count9 !== 4'(i % 10) || wrap9 !== (i == 10) || tc9 !== (i % 10 == 9)) begin
            errors++;
            $display("FAIL max9 edge %0d: count=%0d wrap=%b tc=%b expected %0d/%b/%b",
                     i, count9, wrap9, tc9, i % 10, i == 10, i % 10 == 9);
         end
      end
`ifdef COUNTER_EN_LOAD_EN
      en9 = 0; load9 = 1; load_val9 = 4'd12;
      tick();
      checks++;
      if (count9 !== 4'd9 || wrap9 !== 1'b0) begin
         errors++;
         $display("FAIL load_sat: count=%0d wrap=%b expected 9/0", count9, wrap9);
      end
      en9 = 1; load_val9 = 4'd3;
      #1;
      checks++;
      if (tc9 !== 1'b0) begin
         errors++;
         $display("FAIL load_tc: tc=%b expected 0", tc9);
      end
      tick();
      checks++;
      if (count9 !== 4'd3 || wrap9 !== 1'b0) begin
         errors++;
         $display("FAIL load_val: count=%0d wrap=%b expected 3/0", count9, wrap9);
      end
      load9 = 0;
`endif
      en9 = 0;
   endtask

   task automatic test_random();
      for (int i = 0; i < 500; i++) begin
         en   = $urandom_range(0, 3) != 0;
         clr  = $urandom_range(0, 15) == 0;
         en9  = $urandom_range(0, 3) != 0;
         clr9 = $urandom_range(0, 15) == 0;
`ifdef COUNTER_EN_LOAD_EN
         load = $urandom_range(0, 15) == 0;
         load9 = $urandom_range(0, 11) == 0;
         load_val = 4'($urandom_range(0, 15));
         load_val9 = 4'($urandom_range(0, 15));
`endif
         #1;
         checks++;
         if (count !== 4'(m_cnt) || wrap !== m_wrap || tc !== tc_exp(m_cnt, en, clr, ld, 15)) begin
            errors++;
            $display("FAIL rand16 cycle %0d: count=%0d wrap=%b tc=%b expected %0d/%b/%b", i,
                     count, wrap, tc, m_cnt, m_wrap, tc_exp(m_cnt, en, clr, ld, 15));
         end
         checks++;
         if (count9 !== 4'(m9_cnt) || wrap9 !== m9_wrap || tc9 !== tc_exp(m9_cnt, en9, clr9, ld9, 9)) begin
            errors++;
            $display("FAIL rand9 cycle %0d: count=%0d wrap=%b tc=%b expected %0d/%b/%b", i,
                     count9, wrap9, tc9, m9_cnt, m9_wrap, tc_exp(m9_cnt, en9, clr9, ld9, 9));
         end
         tick();
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_count_wrap();
      test_hold();
      test_clear_priority();
      test_async_reset();
      test_max9();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/counter_en.md
Name: counter_en

Overview:
- Free-running binary up-counter with clock enable, synchronous clear, and terminal-count/wrap indication.
- General-purpose timing and sequencing primitive for control logic, e.g. event counting and simple timebases.
- Single clock domain; no handshake; outputs are registered except tc.

Parameters:
- WIDTH, 4, bit width of count (legal range 1..32).
- MAX_VAL, 2**WIDTH-1, terminal value; count wraps to 0 after reaching it (must satisfy 0 < MAX_VAL <= 2**WIDTH-1).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset; asserts immediately, deasserts synchronously to clk externally.
- en  input  1  count enable; count advances on a rising edge while en=1.
- clr  input  1  synchronous clear; count goes to 0 on the next edge; priority over en.
- count  output  WIDTH  current count value, registered.
- tc  output  1  terminal count, combinational: en & (count==MAX_VAL) & ~clr.
- wrap  output  1  registered one-cycle pulse, high in the cycle after count wrapped MAX_VAL->0.

Behaviour:
- Reset (rst_n=0, any time, asynchronous):
  - count=0, wrap=0.
  - tc=0 because count=0 != MAX_VAL.
  - Holds while rst_n=0 regardless of en or clr.
- Edge priority, evaluated at each rising clk with rst_n=1:
  - clr=1: count<=0, wrap<=0.
  - else en=1 and count==MAX_VAL: count<=0, wrap<=1.
  - else en=1: count<=count+1, wrap<=0.
  - else (en=0): count holds, wrap<=0.
- Latency:
  - count reflects an enabled edge immediately after that edge (1-cycle register latency from en).
  - wrap is a single-cycle pulse, never held across multiple cycles.
- Hold behaviour: en=0 freezes count indefinitely; resuming en continues from the held value with no skipped or repeated values.
- Arithmetic:
  - Unsigned modulo (MAX_VAL+1).
  - Values above MAX_VAL are unreachable; no count sequence may produce them.
- tc:
  - Purely combinational from count, en, clr.
  - Usable as a cascade enable for a following stage.
- Simultaneous events:
  - clr and en both high at MAX_VAL: result is count=0 and wrap=0; clear wins and no wrap is reported.
- Reset mid-count: count returns to 0 asynchronously; after release, counting restarts from 0 on the first enabled edge.
- No X propagation on outputs after reset, for any input combination.

Optional Feature:
- Macro: COUNTER_EN_LOAD_EN.
- When defined, the block adds two ports:
  - load: input, 1 bit.
  - load_val: input, WIDTH bits.
- Load priority and behaviour:
  - Priority order: clr > load > en.
  - load=1 sets count<=load_val on the next edge, with wrap<=0.
  - load_val > MAX_VAL is saturated to MAX_VAL.
  - tc also requires load=0.
- When not defined:
  - The ports do not exist.
  - Behaviour is exactly as in the Behaviour section above.

Test Plan:
- Reset: rst_n=0 for 20 ns with en=0 (10 ns clk period) -> count=0, wrap=0, tc=0 throughout. Releasing rst_n with en=0 keeps count=0.
- Count/wrap: WIDTH=4 default, en=1 for 20 enabled edges from 0 -> count runs 1..15, then 0, then 1..4; wrap pulses exactly once, for one cycle, after the 15->0 transition; tc=1 only while count=15.
- Hold: en=0 for 4 cycles at count=4 -> count stays 4. Re-enable for 5 edges -> count=9, no values skipped.
- Clear priority: clr=1 and en=1 at count=15 -> next count=0, wrap=0, tc=0.
- Async reset mid-run: assert rst_n=0 between edges at count=7 -> count=0 before the next clk edge. After release, the first enabled edge gives count=1.
- MAX_VAL=9 (plus load when COUNTER_EN_LOAD_EN is defined):
  - Counting sequence 0..9,0 with wrap after 9.
  - load=1 with load_val=12 -> count=9.
  - load=1 with load_val=3 and en=1 -> count=3.
